hazard_unit_mc: RTL

//  Next-gen pipeline hazard unit for the 5-stage pipelined CPU (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/long_op_scoreboard.sv | 82 ++++++++
 rtl/hazard_unit_mc.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and long-op FSM states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      LOP_IDLE = 1'b0,
      LOP_BUSY = 1'b1
   } lop_state_t;

   // Select used when only the writeback stage holds a matching result.
   localparam fwd_sel_t FWD_W_ONLY = FWD_W;

   // The M stage holds the younger result, so it wins over W.
   function automatic fwd_sel_t fwdSelect(input logic hitM, input logic hitW);
      if (hitM) begin
         return FWD_M;
      end else if (hitW) begin
         return FWD_W_ONLY;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/long_op_scoreboard.sv
// Long-latency op tracker: countdown FSM holding the pending destination register and
// raising lopStall when the D-stage instruction depends on it (RAW/WAW) or is itself long.
module long_op_scoreboard import hazard_pkg::*; #(
   parameter int unsigned REG_AW   = 6,
   parameter int unsigned LONG_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              LongOpE,
   input  logic              LongOpD,
   input  logic              FlushE,
   input  logic [REG_AW-1:0] WA3E,
   input  logic [REG_AW-1:0] RA1D,
   input  logic [REG_AW-1:0] RA2D,
   input  logic [REG_AW-1:0] WA3D,
   output logic              LongBusy,
   output logic [REG_AW-1:0] LongWA,
   output logic              lopStall
);

   localparam int unsigned CNT_W = $clog2(LONG_LAT);
   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LONG_LAT - 1);

   lop_state_t        stateQ, stateD;
   logic [CNT_W-1:0]  cntQ, cntD;
   logic [REG_AW-1:0] waQ, waD;
   logic              accept;

   // A long op in E is only taken if E is not being bubbled this cycle.
   assign accept = LongOpE && !FlushE;

   // Next-state: load on accept, count down while busy, reload on back-to-back issue.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      waD    = waQ;
      case (stateQ)
         LOP_IDLE: begin
            if (accept) begin
               stateD = LOP_BUSY;
               cntD   = CntLoad;
               waD    = WA3E;
            end
         end
         LOP_BUSY: begin
            if (cntQ == '0) begin
               if (accept) begin
                  cntD = CntLoad;
                  waD  = WA3E;
               end else begin
                  stateD = LOP_IDLE;
               end
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         default: stateD = LOP_IDLE;
      endcase
   end

   // State, countdown and pending destination registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= LOP_IDLE;
         cntQ   <= '0;
         waQ    <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         waQ    <= waD;
      end
   end

   assign LongBusy = (stateQ == LOP_BUSY);
   assign LongWA   = waQ;

   // Any D-stage use or overwrite of the pending register, or a second long op, must wait.
   always_comb begin
      lopStall = LongBusy && ((waQ == RA1D) || (waQ == RA2D) || (waQ == WA3D) || LongOpD);
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit for the 5-stage CPU: M/W forwarding, load-use and long-op stalls,
// PC-write and branch flushes. Define HAZARD_PERF_CNT_EN to add saturating perf counters.
module hazard_unit_mc import hazard_pkg::*; #(
   parameter int unsigned REG_AW   = 6,
   parameter int unsigned LONG_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int unsigned PERF_W   = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] RA1D,
   input  logic [REG_AW-1:0] RA2D,
   input  logic [REG_AW-1:0] WA3D,
   input  logic [REG_AW-1:0] RA1E,
   input  logic [REG_AW-1:0] RA2E,
   input  logic [REG_AW-1:0] WA3E,
   input  logic [REG_AW-1:0] WA3M,
   input  logic [REG_AW-1:0] WA3W,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemToRegE,
   input  logic              LongOpD,
   input  logic              LongOpE,
   input  logic              PCSrcD,
   input  logic              PCSrcE,
   input  logic              PCSrcM,
   input  logic              PCSrcW,
   input  logic              BranchTakenE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output fwd_sel_t          FwdAE,
   output fwd_sel_t          FwdBE,
   output logic              LongBusy,
   output logic [REG_AW-1:0] LongWA
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic              PerfClr,
   output logic [PERF_W-1:0] StallCnt,
   output logic [PERF_W-1:0] FlushCnt,
   output logic [PERF_W-1:0] LongCnt
`endif
);

   logic ldStall;
   logic lopStall;
   logic pcPend;

   long_op_scoreboard #(
      .REG_AW   (REG_AW),
      .LONG_LAT (LONG_LAT)
   ) uScoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .LongOpE  (LongOpE),
      .LongOpD  (LongOpD),
      .FlushE   (FlushE),
      .WA3E     (WA3E),
      .RA1D     (RA1D),
      .RA2D     (RA2D),
      .WA3D     (WA3D),
      .LongBusy (LongBusy),
      .LongWA   (LongWA),
      .lopStall (lopStall)
   );

   // Operand forwarding into E, full-width register compares.
   always_comb begin
      FwdAE = fwdSelect(RegWriteM && (WA3M == RA1E), RegWriteW && (WA3W == RA1E));
      FwdBE = fwdSelect(RegWriteM && (WA3M == RA2E), RegWriteW && (WA3W == RA2E));
   end

   // Stall and flush generation.
   always_comb begin
      ldStall = MemToRegE && ((WA3E == RA1D) || (WA3E == RA2D));
      pcPend  = PCSrcD | PCSrcE | PCSrcM;
      StallD  = ldStall | lopStall;
      StallF  = StallD | pcPend;
      FlushD  = pcPend | PCSrcW | BranchTakenE;
      FlushE  = StallD | BranchTakenE;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stallCntQ, flushCntQ, longCntQ;

   // Saturating event counters with synchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCntQ <= '0;
         flushCntQ <= '0;
         longCntQ  <= '0;
      end else if (PerfClr) begin
         stallCntQ <= '0;
         flushCntQ <= '0;
         longCntQ  <= '0;
      end else begin
         if (StallD && (stallCntQ != '1)) stallCntQ <= stallCntQ + PERF_W'(1);
         if (FlushE && (flushCntQ != '1)) flushCntQ <= flushCntQ + PERF_W'(1);
         if (LongBusy && (longCntQ != '1)) longCntQ <= longCntQ + PERF_W'(1);
      end
   end

   assign StallCnt = stallCntQ;
   assign FlushCnt = flushCntQ;
   assign LongCnt  = longCntQ;
`endif

endmodule
